// File: rtl/audio_period_scheduler_pkg.sv
// Shared constants for the audio period scheduler: state encoding,
// register map and CTRL bit positions.
package audio_period_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_I2S   = 3'd1,
        ST_FILL  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_PERIOD = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_UCNT   = 3'd3;

    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_CLR_IRQ = 1;
    localparam int CTRL_CLR_ERR = 2;

    localparam int STATUS_STATE_LSB = 24;
    localparam int STATUS_OVERRUN   = 23;
    localparam int STATUS_UNDERRUN  = 22;
    localparam int STATUS_IRQ       = 21;

    // A period longer than the FIFO can never be reached, so cap it at the depth.
    function automatic logic [31:0] clamp_period(input logic [31:0] value, input int fifo_width);
        logic [31:0] limit;
        limit = 32'd1 << fifo_width;
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/audio_period_scheduler_if.sv
// CPU register bus between the host CPU and the audio period scheduler.
interface audio_period_scheduler_if;
    logic [2:0]  address;
    logic        write;
    logic        read;
    logic [31:0] datain;
    logic [31:0] dataout;

    modport master (output address, output write, output read, output datain, input dataout);
    modport slave  (input address, input write, input read, input datain, output dataout);
endinterface

// File: rtl/audio_period_scheduler_syncro_2.sv
// Two-flop synchronizer for a single asynchronous level signal.
module syncro_2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/audio_period_scheduler.sv
// Decides when the synth engine computes the next stereo frame, either paced
// by the codec word clock or by bursting frames into the host FIFO.
//
// state | meaning
// IDLE  | disabled or just reconfigured; level held at 0
// I2S   | one trig per synchronized rising edge of lrck
// FILL  | waiting for the engine to go idle before the next trig
// WAIT  | frame in flight; xxxx_top bumps the level
// DRAIN | period reached; hold until the host empties the FIFO
module audio_period_scheduler
    import audio_period_scheduler_pkg::*;
#(
    parameter int FIFO_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    audio_period_scheduler_if.slave   bus,
    input  logic                      lrck,
    input  logic                      run,
    input  logic                      xxxx_top,
    input  logic                      l_read,
    input  logic                      r_read,
    output logic                      trig,
    output logic                      i2s_enable,
    output logic                      period_irq,
    output logic                      underrun,
    output logic                      overrun
);
    localparam int LW = FIFO_WIDTH + 1;
    localparam logic [LW-1:0] LEVEL_MAX = {1'b1, {FIFO_WIDTH{1'b0}}};

    state_t          state;
    state_t          state_nxt;
    logic            trig_nxt;
    logic            enable;
    logic [LW-1:0]   period;
    logic [LW-1:0]   level;
    logic [LW-1:0]   level_nxt;
    logic [15:0]     ucnt;
    logic [31:0]     rd_data;

    logic            lrck_s;
    logic            lrck_d;
    logic            lrck_rise;

    logic            wr_ctrl;
    logic            wr_period;
    logic            force_idle;
    logic            active;
    logic            top_in_wait;
    logic            top_stray;
    logic            pop_ok;
    logic            pop_under;
    logic            inc;
    logic            reached;
    logic            set_overrun;

    // Left pops are observed by the host side only; a frame is consumed on r_read.
    logic            unused_l_read;
    assign unused_l_read = l_read;

    syncro_2 u_lrck_sync (
        .clk   (clk),
        .reset (reset),
        .d     (lrck),
        .q     (lrck_s)
    );

    assign lrck_rise   = lrck_s & ~lrck_d;
    assign i2s_enable  = enable && (period == '0);

    assign wr_ctrl     = bus.write && (bus.address == ADDR_CTRL);
    assign wr_period   = bus.write && (bus.address == ADDR_PERIOD);
    assign force_idle  = wr_period || (wr_ctrl && !bus.datain[CTRL_ENABLE]);

    assign active      = (state != ST_IDLE);
    assign top_in_wait = xxxx_top && (state == ST_WAIT);
    assign top_stray   = xxxx_top && ((state == ST_FILL) || (state == ST_DRAIN));
    assign pop_ok      = active && r_read && (level != '0);
    assign pop_under   = active && r_read && (level == '0);
    assign inc         = top_in_wait && (level != LEVEL_MAX);
    assign reached     = top_in_wait && (level_nxt == period);
    assign set_overrun = top_stray || ((state == ST_I2S) && lrck_rise && run);

    always_comb begin
        level_nxt = level;
        case ({inc, pop_ok})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    always_comb begin
        state_nxt = state;
        trig_nxt  = 1'b0;
        if (force_idle) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable)
                        state_nxt = (period == '0) ? ST_I2S : ST_FILL;
                end
                ST_I2S: begin
                    trig_nxt = lrck_rise;
                end
                ST_FILL: begin
                    if (!run) begin
                        trig_nxt  = 1'b1;
                        state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (xxxx_top)
                        state_nxt = reached ? ST_DRAIN : ST_FILL;
                end
                ST_DRAIN: begin
                    if (level == '0)
                        state_nxt = ST_FILL;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (bus.address)
            ADDR_CTRL:   rd_data[CTRL_ENABLE] = enable;
            ADDR_PERIOD: rd_data[LW-1:0] = period;
            ADDR_STATUS: begin
                rd_data[31:STATUS_STATE_LSB] = {5'd0, state};
                rd_data[STATUS_OVERRUN]      = overrun;
                rd_data[STATUS_UNDERRUN]     = underrun;
                rd_data[STATUS_IRQ]          = period_irq;
                rd_data[LW-1:0]              = level;
            end
            ADDR_UCNT:   rd_data[15:0] = ucnt;
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            trig        <= 1'b0;
            lrck_d      <= 1'b0;
            enable      <= 1'b0;
            period      <= '0;
            level       <= '0;
            period_irq  <= 1'b0;
            underrun    <= 1'b0;
            overrun     <= 1'b0;
            ucnt        <= '0;
            bus.dataout <= '0;
        end else begin
            state  <= state_nxt;
            trig   <= trig_nxt;
            lrck_d <= lrck_s;

            if (wr_ctrl)
                enable <= bus.datain[CTRL_ENABLE];
            if (wr_period)
                period <= LW'(clamp_period(bus.datain, FIFO_WIDTH));

            level <= force_idle ? '0 : level_nxt;

            // Set beats a simultaneous W1C; reconfiguration beats both.
            if (force_idle)
                period_irq <= 1'b0;
            else if (reached)
                period_irq <= 1'b1;
            else if (wr_ctrl && bus.datain[CTRL_CLR_IRQ])
                period_irq <= 1'b0;

            if (pop_under)
                underrun <= 1'b1;
            else if (wr_ctrl && bus.datain[CTRL_CLR_ERR])
                underrun <= 1'b0;

            if (set_overrun)
                overrun <= 1'b1;
            else if (wr_ctrl && bus.datain[CTRL_CLR_ERR])
                overrun <= 1'b0;

            if (pop_under && (ucnt != 16'hFFFF))
                ucnt <= ucnt + 16'd1;

            if (bus.read)
                bus.dataout <= rd_data;
        end
    end
endmodule

// File: tb/tb_audio_period_scheduler.sv
// Directed and randomized checks of the audio period scheduler against
// transaction-level expectations (trig counts, levels, flags, counters).
module tb_audio_period_scheduler;
    logic clk = 1'b0;
    logic reset;
    logic lrck, l_read, r_read;
    logic dir_run, eng_run, dir_top, eng_top, engine_en;
    logic run, xxxx_top;
    logic trig, i2s_enable, period_irq, underrun, overrun;

    int errors = 0;
    int checks = 0;
    int trig_cnt = 0;
    int dbl_trig = 0;
    logic prev_trig = 1'b0;

    logic [31:0] d;
    int n, tc0, p, k, exp_ucnt;
    bit ok;

    audio_period_scheduler_if bus ();

    assign run      = dir_run | eng_run;
    assign xxxx_top = dir_top | eng_top;

    always #5 clk = ~clk;

    audio_period_scheduler #(.FIFO_WIDTH(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .lrck       (lrck),
        .run        (run),
        .xxxx_top   (xxxx_top),
        .l_read     (l_read),
        .r_read     (r_read),
        .trig       (trig),
        .i2s_enable (i2s_enable),
        .period_irq (period_irq),
        .underrun   (underrun),
        .overrun    (overrun)
    );

    always @(posedge clk) begin
        if (trig) trig_cnt <= trig_cnt + 1;
        if (trig && prev_trig) dbl_trig <= dbl_trig + 1;
        prev_trig <= trig;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int c);
        repeat (c) tick();
    endtask

    // Engine model: busy for 10 cycles after each trig, then a one-cycle xxxx_top.
    initial begin
        eng_run = 1'b0;
        eng_top = 1'b0;
        forever begin
            tick();
            if (engine_en && trig) begin
                eng_run = 1'b1;
                ticks(9);
                eng_top = 1'b1;
                eng_run = 1'b0;
                tick();
                eng_top = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_word(input int st, input bit ovr, input bit und,
                                                input bit irq, input int lvl);
        return (32'(st) << 24) | (32'(ovr) << 23) | (32'(und) << 22) | (32'(irq) << 21) | 32'(lvl);
    endfunction

    task automatic cpu_write(input logic [2:0] a, input logic [31:0] v);
        bus.address = a;
        bus.datain  = v;
        bus.write   = 1'b1;
        tick();
        bus.write   = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [31:0] v);
        bus.address = a;
        bus.read    = 1'b1;
        tick();
        bus.read    = 1'b0;
        v = bus.dataout;
    endtask

    task automatic pop();
        l_read = 1'b1;
        tick();
        l_read = 1'b0;
        r_read = 1'b1;
        tick();
        r_read = 1'b0;
    endtask

    task automatic pulse_top();
        dir_top = 1'b1;
        tick();
        dir_top = 1'b0;
    endtask

    task automatic lrck_pulse();
        lrck = 1'b1;
        ticks(2);
        check("lrck_lat2", trig, 1'b0);
        tick();
        check("lrck_lat3", trig, 1'b1);
        tick();
        check("trig_width", trig, 1'b0);
        lrck = 1'b0;
        ticks($urandom_range(4, 12));
    endtask

    task automatic fill_round(input int per);
        logic [31:0] s;
        bit got;
        cpu_write(3'd1, 32'(per));
        engine_en = 1'b1;
        tc0 = trig_cnt;
        cpu_write(3'd0, 32'd1);
        got = 1'b0;
        for (int i = 0; i < per * 15 + 50; i++) begin
            if (period_irq) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("fill_irq_timeout", 32'(got), 32'd1);
        ticks(20);
        check("fill_trig_count", 32'(trig_cnt - tc0), 32'(per));
        check("fill_irq", period_irq, 1'b1);
        cpu_read(3'd2, s);
        check("fill_status", s, status_word(4, 0, 0, 1, per));
    endtask

    initial begin
        reset = 1'b1;
        lrck = 1'b0; l_read = 1'b0; r_read = 1'b0;
        dir_run = 1'b0; dir_top = 1'b0; engine_en = 1'b0;
        bus.address = '0; bus.write = 1'b0; bus.read = 1'b0; bus.datain = '0;
        exp_ucnt = 0;
        ticks(3);
        reset = 1'b0;
        tick();

        check("rst_trig", trig, 1'b0);
        check("rst_i2s_enable", i2s_enable, 1'b0);
        check("rst_irq", period_irq, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_dataout", bus.dataout, 32'd0);
        cpu_read(3'd2, d); check("rst_status", d, 32'd0);
        cpu_read(3'd3, d); check("rst_ucnt", d, 32'd0);
        cpu_read(3'd1, d); check("rst_period", d, 32'd0);

        // I2S mode
        cpu_write(3'd0, 32'd1);
        check("i2s_enable_on", i2s_enable, 1'b1);
        tc0 = trig_cnt;
        n = $urandom_range(3, 6);
        for (int i = 0; i < n; i++) lrck_pulse();
        check("i2s_trig_count", 32'(trig_cnt - tc0), 32'(n));
        check("i2s_no_overrun", overrun, 1'b0);
        cpu_read(3'd2, d); check("i2s_status", d, status_word(1, 0, 0, 0, 0));

        dir_run = 1'b1;
        lrck_pulse();
        dir_run = 1'b0;
        check("i2s_overrun", overrun, 1'b1);
        cpu_write(3'd0, 32'd5);
        check("overrun_w1c", overrun, 1'b0);
        check("i2s_still_enabled", i2s_enable, 1'b1);
        cpu_write(3'd0, 32'd0);
        check("i2s_enable_off", i2s_enable, 1'b0);

        // Period fill, then drain and refill
        fill_round(4);
        for (int j = 1; j <= 4; j++) begin
            pop();
            cpu_read(3'd2, d);
            check("drain_level", d[6:0], 7'(4 - j));
        end
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (trig) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("refill_trig", 32'(ok), 32'd1);
        check("irq_sticky", period_irq, 1'b1);
        cpu_write(3'd0, 32'd3);
        check("irq_w1c", period_irq, 1'b0);
        engine_en = 1'b0;
        ticks(20);
        cpu_write(3'd0, 32'd0);
        check("drain_no_underrun", underrun, 1'b0);

        // Underrun
        cpu_write(3'd1, 32'd8);
        cpu_write(3'd0, 32'd1);
        ticks(4);
        n = $urandom_range(1, 3);
        repeat (n) begin
            r_read = 1'b1;
            tick();
            r_read = 1'b0;
            tick();
        end
        exp_ucnt += n;
        check("underrun_set", underrun, 1'b1);
        cpu_read(3'd3, d); check("ucnt", d, 32'(exp_ucnt));
        cpu_read(3'd2, d); check("underrun_status", d, status_word(3, 0, 1, 0, 0));
        cpu_write(3'd0, 32'd5);
        check("underrun_w1c", underrun, 1'b0);
        cpu_read(3'd3, d); check("ucnt_kept", d, 32'(exp_ucnt));

        // Simultaneous increment and decrement at level 2, then reconfigure at level 3
        pulse_top(); ticks(3);
        pulse_top(); ticks(3);
        dir_top = 1'b1; r_read = 1'b1;
        tick();
        dir_top = 1'b0; r_read = 1'b0;
        cpu_read(3'd2, d); check("simul_level", d, status_word(2, 0, 0, 0, 2));
        ticks(2);
        pulse_top(); ticks(3);
        cpu_read(3'd2, d); check("level3", d, status_word(3, 0, 0, 0, 3));
        cpu_write(3'd1, 32'd8);
        cpu_read(3'd2, d); check("reconf_idle", d, status_word(0, 0, 0, 0, 0));
        cpu_read(3'd2, d); check("reconf_fill", d, status_word(2, 0, 0, 0, 0));
        ticks(2);

        // xxxx_top in DRAIN
        cpu_write(3'd1, 32'd2);
        ticks(3);
        pulse_top(); ticks(3);
        pulse_top(); tick();
        check("drain_irq", period_irq, 1'b1);
        cpu_read(3'd2, d); check("drain_status", d, status_word(4, 0, 0, 1, 2));
        pulse_top();
        check("drain_overrun", overrun, 1'b1);
        cpu_read(3'd2, d); check("drain_overrun_status", d, status_word(4, 1, 0, 1, 2));

        // Reset mid-frame
        cpu_write(3'd1, 32'd8);
        ticks(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_ucnt = 0;
        pulse_top();
        tick();
        check("post_reset_overrun", overrun, 1'b0);
        check("post_reset_irq", period_irq, 1'b0);
        cpu_read(3'd2, d); check("post_reset_status", d, 32'd0);
        cpu_read(3'd3, d); check("post_reset_ucnt", d, 32'(exp_ucnt));
        cpu_read(3'd0, d); check("post_reset_ctrl", d, 32'd0);

        // PERIOD clamp and unmapped read
        cpu_write(3'd1, 32'd200);
        cpu_read(3'd1, d); check("period_clamp", d, 32'd64);
        cpu_write(3'd1, 32'd64);
        cpu_read(3'd1, d); check("period_max", d, 32'd64);
        cpu_read(3'd5, d); check("unmapped_read", d, 32'd0);

        // Randomized fill/partial drain rounds
        repeat (3) begin
            p = $urandom_range(1, 10);
            fill_round(p);
            k = $urandom_range(0, p - 1);
            repeat (k) pop();
            cpu_read(3'd2, d); check("rand_drain_status", d, status_word(4, 0, 0, 1, p - k));
            engine_en = 1'b0;
            cpu_write(3'd0, 32'd0);
            check("rand_disable_irq", period_irq, 1'b0);
        end

        check("trig_single_cycle", 32'(dbl_trig), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
